// File: rtl/arp_pkg.sv
// Shared ARP constants, field offsets and parser state encoding.
// The reply encoder imports the same package, so both ends agree on framing.
package arp_pkg;

  localparam logic [15:0] ARP_HW_TYPE    = 16'h0001;
  localparam logic [15:0] ARP_PROT_TYPE  = 16'h0800;
  localparam logic [7:0]  ARP_HW_LEN     = 8'h06;
  localparam logic [7:0]  ARP_PROT_LEN   = 8'h04;
  localparam logic [15:0] ARP_OP_REQUEST = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
  localparam int          ARP_LEN        = 28;

  localparam logic [4:0] OFF_HTYPE = 5'd0;
  localparam logic [4:0] OFF_PTYPE = 5'd2;
  localparam logic [4:0] OFF_HLEN  = 5'd4;
  localparam logic [4:0] OFF_PLEN  = 5'd5;
  localparam logic [4:0] OFF_OPER  = 5'd6;
  localparam logic [4:0] OFF_SHA   = 5'd8;
  localparam logic [4:0] OFF_SPA   = 5'd14;
  localparam logic [4:0] OFF_THA   = 5'd18;
  localparam logic [4:0] OFF_TPA   = 5'd24;
  localparam logic [4:0] ARP_LAST  = 5'(ARP_LEN - 1);

  typedef logic [1:0] arp_state_t;

  localparam arp_state_t ST_IDLE  = 2'd0;
  localparam arp_state_t ST_PARSE = 2'd1;
  localparam arp_state_t ST_PAD   = 2'd2;
  localparam arp_state_t ST_HOLD  = 2'd3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/arp_field_match.sv
// Combinational expected-byte check for the fixed fields of an ARP request.
// Bytes outside the checked fields (addresses, THA) always report a match.
module arp_field_match
  import arp_pkg::*;
#(
  parameter logic [31:0] IP_ADDR = 32'h0
) (
  input  logic [4:0] idx,
  input  logic [7:0] din,
  output logic       match
);

  always_comb begin
    match = 1'b1;
    case (idx)
      OFF_HTYPE:         match = (din == ARP_HW_TYPE[15:8]);
      OFF_HTYPE + 5'd1:  match = (din == ARP_HW_TYPE[7:0]);
      OFF_PTYPE:         match = (din == ARP_PROT_TYPE[15:8]);
      OFF_PTYPE + 5'd1:  match = (din == ARP_PROT_TYPE[7:0]);
      OFF_HLEN:          match = (din == ARP_HW_LEN);
      OFF_PLEN:          match = (din == ARP_PROT_LEN);
      OFF_OPER:          match = (din == ARP_OP_REQUEST[15:8]);
      OFF_OPER + 5'd1:   match = (din == ARP_OP_REQUEST[7:0]);
      OFF_TPA:           match = (din == IP_ADDR[31:24]);
      OFF_TPA + 5'd1:    match = (din == IP_ADDR[23:16]);
      OFF_TPA + 5'd2:    match = (din == IP_ADDR[15:8]);
      OFF_TPA + 5'd3:    match = (din == IP_ADDR[7:0]);
      default:           match = 1'b1;
    endcase
  end

endmodule

// File: rtl/arp_request_parse.sv
// ARP request parser: validates a request for our IP, latches requester MAC/IP
// and holds a reply request until the tx path takes it.
//
// state | meaning
// IDLE  | waiting for start of an ARP payload
// PARSE | consuming header bytes 0..27
// PAD   | ignoring Ethernet pad, waiting for frame_end verdict
// HOLD  | reply pending, tha/tpa stable until reply_ready
module arp_request_parse
  import arp_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h0,
  parameter logic [31:0] IP_ADDR  = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  input  logic        din_sof,
  input  logic        frame_end,
  input  logic        frame_good,
  input  logic        reply_ready,
  output logic        reply_valid,
  output logic [47:0] tha,
  output logic [31:0] tpa,
  output logic [15:0] drop_cnt
);

  arp_state_t  state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        bad_q, bad_d;
  logic [47:0] sha_q, sha_d;
  logic [31:0] spa_q, spa_d;
  logic [47:0] tha_q, tha_d;
  logic [31:0] tpa_q, tpa_d;
  logic        reply_valid_q, reply_valid_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  logic        sof_byte;
  logic        take_byte;
  logic [4:0]  byte_idx;
  logic        byte_ok;

  assign sof_byte = din_valid && din_sof;
  assign byte_idx = sof_byte ? 5'd0 : idx_q;

  arp_field_match #(.IP_ADDR(IP_ADDR)) u_field_match (
    .idx   (byte_idx),
    .din   (din),
    .match (byte_ok)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    bad_d         = bad_q;
    sha_d         = sha_q;
    spa_d         = spa_q;
    tha_d         = tha_q;
    tpa_d         = tpa_q;
    reply_valid_d = reply_valid_q;
    drop_cnt_d    = drop_cnt_q;
    take_byte     = 1'b0;

    case (state_q)
      ST_IDLE:  take_byte = sof_byte;
      ST_PARSE: begin
        if (sof_byte) drop_cnt_d = sat_inc16(drop_cnt_d);
        take_byte = din_valid;
      end
      ST_PAD: begin
        if (sof_byte) drop_cnt_d = sat_inc16(drop_cnt_d);
        take_byte = sof_byte;
      end
      ST_HOLD: begin
        if (reply_ready) begin
          reply_valid_d = 1'b0;
          state_d       = ST_IDLE;
          take_byte     = sof_byte;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Byte is folded in first so a coincident frame_end sees its effect.
    if (take_byte) begin
      bad_d = (sof_byte ? 1'b0 : bad_q) | ~byte_ok;
      if (byte_idx >= OFF_SHA && byte_idx < OFF_SPA) sha_d = {sha_q[39:0], din};
      if (byte_idx >= OFF_SPA && byte_idx < OFF_THA) spa_d = {spa_q[23:0], din};
      if (byte_idx == ARP_LAST) begin
        state_d = ST_PAD;
        idx_d   = byte_idx;
      end else begin
        state_d = ST_PARSE;
        idx_d   = byte_idx + 5'd1;
      end
    end

    if (frame_end) begin
      if (state_q == ST_HOLD) begin
        drop_cnt_d = sat_inc16(drop_cnt_d);
      end else if (state_d == ST_PARSE) begin
        drop_cnt_d = sat_inc16(drop_cnt_d);
        state_d    = ST_IDLE;
      end else if (state_d == ST_PAD) begin
        if (frame_good && !bad_d && sha_d != MAC_ADDR) begin
          tha_d         = sha_d;
          tpa_d         = spa_d;
          reply_valid_d = 1'b1;
          state_d       = ST_HOLD;
        end else begin
          drop_cnt_d = sat_inc16(drop_cnt_d);
          state_d    = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= 5'd0;
      bad_q         <= 1'b0;
      sha_q         <= 48'h0;
      spa_q         <= 32'h0;
      tha_q         <= 48'h0;
      tpa_q         <= 32'h0;
      reply_valid_q <= 1'b0;
      drop_cnt_q    <= 16'h0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      bad_q         <= bad_d;
      sha_q         <= sha_d;
      spa_q         <= spa_d;
      tha_q         <= tha_d;
      tpa_q         <= tpa_d;
      reply_valid_q <= reply_valid_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign reply_valid = reply_valid_q;
  assign tha         = tha_q;
  assign tpa         = tpa_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_arp_request_parse.sv
// Directed bench for arp_request_parse: accept/drop paths, runt, restart,
// held reply during a second request, and reset in PARSE and HOLD.
module tb_arp_request_parse;

  localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_11;
  localparam logic [31:0] MY_IP  = 32'hC0A8_0101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_sof = 1'b0;
  logic        frame_end = 1'b0;
  logic        frame_good = 1'b0;
  logic        reply_ready = 1'b0;
  logic        reply_valid;
  logic [47:0] tha;
  logic [31:0] tpa;
  logic [15:0] drop_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic rv_before;

  always #5 clk = ~clk;

  arp_request_parse #(.MAC_ADDR(MY_MAC), .IP_ADDR(MY_IP)) dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .din_valid   (din_valid),
    .din_sof     (din_sof),
    .frame_end   (frame_end),
    .frame_good  (frame_good),
    .reply_ready (reply_ready),
    .reply_valid (reply_valid),
    .tha         (tha),
    .tpa         (tpa),
    .drop_cnt    (drop_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives nbytes of an ARP payload (zero pad beyond 28), optionally followed by frame_end.
  task automatic send_frame(input logic [47:0] sha, input logic [31:0] spa,
                            input logic [31:0] tpa_f, input logic [15:0] op,
                            input int nbytes, input logic good, input bit do_end,
                            output logic rv_pre);
    logic [7:0] b [28];
    b[0] = 8'h00; b[1] = 8'h01; b[2] = 8'h08; b[3] = 8'h00;
    b[4] = 8'h06; b[5] = 8'h04; b[6] = op[15:8]; b[7] = op[7:0];
    for (int i = 0; i < 6; i++) b[8 + i]  = sha[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) b[14 + i] = spa[31 - 8*i -: 8];
    for (int i = 0; i < 6; i++) b[18 + i] = 8'h00;
    for (int i = 0; i < 4; i++) b[24 + i] = tpa_f[31 - 8*i -: 8];
    for (int i = 0; i < nbytes; i++) begin
      din       = (i < 28) ? b[i] : 8'h00;
      din_valid = 1'b1;
      din_sof   = (i == 0);
      tick();
    end
    din_valid = 1'b0;
    din_sof   = 1'b0;
    rv_pre    = reply_valid;
    if (do_end) begin
      frame_end  = 1'b1;
      frame_good = good;
      tick();
      frame_end  = 1'b0;
      frame_good = 1'b0;
    end
  endtask

  task automatic release_reply();
    reply_ready = 1'b1;
    tick();
    reply_ready = 1'b0;
  endtask

  initial begin
    tick(); tick();
    check("reset_rv", 64'(reply_valid), 64'd0);
    check("reset_tha", 64'(tha), 64'd0);
    check("reset_tpa", 64'(tpa), 64'd0);
    check("reset_drop", 64'(drop_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // Valid request with full Ethernet pad
    send_frame(48'h0200000000AA, 32'hC0A80107, MY_IP, 16'h0001, 46, 1'b1, 1'b1, rv_before);
    check("t1_rv_before_end", 64'(rv_before), 64'd0);
    check("t1_rv_after_end", 64'(reply_valid), 64'd1);
    check("t1_tha", 64'(tha), 64'h0200000000AA);
    check("t1_tpa", 64'(tpa), 64'hC0A80107);
    check("t1_drop", 64'(drop_cnt), 64'd0);
    release_reply();
    check("t1_rv_released", 64'(reply_valid), 64'd0);

    // Wrong TPA, reply opcode, own echo
    send_frame(48'h0200000000AA, 32'hC0A80107, MY_IP + 32'd1, 16'h0001, 28, 1'b1, 1'b1, rv_before);
    check("t2_tpa_rv", 64'(reply_valid), 64'd0);
    check("t2_tpa_drop", 64'(drop_cnt), 64'd1);
    send_frame(48'h0200000000AA, 32'hC0A80107, MY_IP, 16'h0002, 28, 1'b1, 1'b1, rv_before);
    check("t2_op_rv", 64'(reply_valid), 64'd0);
    check("t2_op_drop", 64'(drop_cnt), 64'd2);
    send_frame(MY_MAC, 32'hC0A80107, MY_IP, 16'h0001, 28, 1'b1, 1'b1, rv_before);
    check("t2_echo_rv", 64'(reply_valid), 64'd0);
    check("t2_echo_drop", 64'(drop_cnt), 64'd3);

    // Bad FCS keeps previous tha/tpa
    send_frame(48'h020000000099, 32'hC0A80199, MY_IP, 16'h0001, 28, 1'b0, 1'b1, rv_before);
    check("t3_rv", 64'(reply_valid), 64'd0);
    check("t3_drop", 64'(drop_cnt), 64'd4);
    check("t3_tha_kept", 64'(tha), 64'h0200000000AA);
    check("t3_tpa_kept", 64'(tpa), 64'hC0A80107);

    // Runt, then a truncated frame restarted by a new sof
    send_frame(48'h0200000000AA, 32'hC0A80107, MY_IP, 16'h0001, 20, 1'b1, 1'b1, rv_before);
    check("t4_runt_rv", 64'(reply_valid), 64'd0);
    check("t4_runt_drop", 64'(drop_cnt), 64'd5);
    send_frame(48'h0200000000AA, 32'hC0A80107, MY_IP, 16'h0001, 10, 1'b1, 1'b0, rv_before);
    send_frame(48'h0200000000BB, 32'hC0A80108, MY_IP, 16'h0001, 28, 1'b1, 1'b1, rv_before);
    check("t4_restart_rv", 64'(reply_valid), 64'd1);
    check("t4_restart_drop", 64'(drop_cnt), 64'd6);
    check("t4_restart_tha", 64'(tha), 64'h0200000000BB);
    check("t4_restart_tpa", 64'(tpa), 64'hC0A80108);
    release_reply();

    // Held reply while a second request arrives
    send_frame(48'h0200000000CC, 32'hC0A80109, MY_IP, 16'h0001, 28, 1'b1, 1'b1, rv_before);
    check("t5_rv", 64'(reply_valid), 64'd1);
    send_frame(48'h0200000000DD, 32'hC0A8010A, MY_IP, 16'h0001, 28, 1'b1, 1'b1, rv_before);
    for (int i = 0; i < 20; i++) tick();
    check("t5_rv_held", 64'(reply_valid), 64'd1);
    check("t5_tha_held", 64'(tha), 64'h0200000000CC);
    check("t5_tpa_held", 64'(tpa), 64'hC0A80109);
    check("t5_drop_lost", 64'(drop_cnt), 64'd7);
    release_reply();
    check("t5_rv_released", 64'(reply_valid), 64'd0);

    // Reset mid-PARSE
    send_frame(48'h0200000000EE, 32'hC0A8010B, MY_IP, 16'h0001, 15, 1'b1, 1'b0, rv_before);
    rst = 1'b1;
    tick();
    check("t6_parse_rst_drop", 64'(drop_cnt), 64'd0);
    check("t6_parse_rst_tha", 64'(tha), 64'd0);
    rst = 1'b0;
    send_frame(48'h0200000000EE, 32'hC0A8010B, MY_IP, 16'h0001, 28, 1'b1, 1'b1, rv_before);
    check("t6_after_rst_rv", 64'(reply_valid), 64'd1);
    check("t6_after_rst_tha", 64'(tha), 64'h0200000000EE);
    check("t6_after_rst_drop", 64'(drop_cnt), 64'd0);

    // Reset in HOLD discards the pending reply
    rst = 1'b1;
    tick();
    check("t6_hold_rst_rv", 64'(reply_valid), 64'd0);
    check("t6_hold_rst_tha", 64'(tha), 64'd0);
    check("t6_hold_rst_tpa", 64'(tpa), 64'd0);
    rst = 1'b0;
    send_frame(48'h0200000000FF, 32'hC0A8010C, MY_IP, 16'h0001, 28, 1'b1, 1'b1, rv_before);
    check("t6_final_rv_before", 64'(rv_before), 64'd0);
    check("t6_final_rv", 64'(reply_valid), 64'd1);
    check("t6_final_tpa", 64'(tpa), 64'hC0A8010C);
    release_reply();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
